// File: rtl/aes_pnm_stream_ctrl_if.sv
// Bundle of host-stream, key-load, AES-core and status signals for aes_pnm_stream_ctrl.
// master = the controller's view; slave = the host/core side.
interface aes_pnm_stream_ctrl_if #(
    parameter int CNT_W = 16
);
    logic             key_wr_en;
    logic [3:0]       key_wr_addr;
    logic [7:0]       key_wr_data;
    logic             mode_enc;
    logic             in_valid;
    logic             in_ready;
    logic [7:0]       in_data;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_data;
    logic             aes_start;
    logic             aes_enc_dec;
    logic [127:0]     aes_state_init;
    logic             aes_state_init_en;
    logic             aes_done;
    logic [127:0]     aes_state_out;
    logic [7:0]       key_00, key_10, key_20, key_30;
    logic [7:0]       key_01, key_11, key_21, key_31;
    logic [7:0]       key_02, key_12, key_22, key_32;
    logic [7:0]       key_03, key_13, key_23, key_33;
    logic             busy;
    logic             err_timeout;
    logic [CNT_W-1:0] blk_count;

    modport master (
        input  key_wr_en, key_wr_addr, key_wr_data, mode_enc,
        input  in_valid, in_data, out_ready, aes_done, aes_state_out,
        output in_ready, out_valid, out_data,
        output aes_start, aes_enc_dec, aes_state_init, aes_state_init_en,
        output key_00, key_10, key_20, key_30, key_01, key_11, key_21, key_31,
        output key_02, key_12, key_22, key_32, key_03, key_13, key_23, key_33,
        output busy, err_timeout, blk_count
    );

    modport slave (
        output key_wr_en, key_wr_addr, key_wr_data, mode_enc,
        output in_valid, in_data, out_ready, aes_done, aes_state_out,
        input  in_ready, out_valid, out_data,
        input  aes_start, aes_enc_dec, aes_state_init, aes_state_init_en,
        input  key_00, key_10, key_20, key_30, key_01, key_11, key_21, key_31,
        input  key_02, key_12, key_22, key_32, key_03, key_13, key_23, key_33,
        input  busy, err_timeout, blk_count
    );
endinterface

// File: rtl/aes_pnm_stream_ctrl.sv
// Host-side sequencer for aes_pnm_top: packs 16 ingress bytes into a block, runs one
// AES operation through the start/done handshake, and streams the 16 result bytes back out.
module aes_pnm_stream_ctrl #(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int CNT_W          = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    aes_pnm_stream_ctrl_if.master bus
);
    localparam int                WAIT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_FILL,
        S_LOAD,
        S_START,
        S_WAIT,
        S_CAPTURE,
        S_DRAIN
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [127:0]      r_in_buf;
    logic [127:0]      r_out_buf;
    logic [127:0]      r_state_init;
    logic [127:0]      w_in_buf_nxt;
    logic [3:0]        r_in_idx;
    logic [3:0]        r_out_idx;
    logic [WAIT_W-1:0] r_wait_cnt;
    logic              r_enc_dec;
    logic              r_err_timeout;
    logic [CNT_W-1:0]  r_blk_count;
    logic [7:0]        r_key [16];
    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_init_en;
    logic              w_start;
    logic              w_in_acc;
    logic              w_in_last;
    logic              w_out_acc;
    logic              w_timeout;
    logic              w_capture;
    logic [6:0]        w_in_lsb;
    logic [6:0]        w_out_lsb;

    // Byte i sits at [127-8i -: 8]; its low bit index is 8*(15-i).
    assign w_in_lsb  = {~r_in_idx, 3'b000};
    assign w_out_lsb = {~r_out_idx, 3'b000};

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_FILL;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        w_init_en   = 1'b0;
        w_start     = 1'b0;
        w_in_acc    = 1'b0;
        w_in_last   = 1'b0;
        w_out_acc   = 1'b0;
        w_timeout   = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            S_FILL: begin
                w_in_ready = 1'b1;
                w_in_acc   = bus.in_valid;
                if (bus.in_valid && (r_in_idx == 4'd15)) begin
                    w_in_last   = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_init_en   = 1'b1;
                w_state_nxt = S_START;
            end
            S_START: begin
                w_start     = 1'b1;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                // A done arriving on the final allowed cycle still wins over the timeout.
                if (bus.aes_done) begin
                    w_state_nxt = S_CAPTURE;
                end else if (r_wait_cnt == WAIT_LAST) begin
                    w_timeout   = 1'b1;
                    w_state_nxt = S_FILL;
                end
            end
            S_CAPTURE: begin
                w_capture   = 1'b1;
                w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                w_out_valid = 1'b1;
                w_out_acc   = bus.out_ready;
                if (bus.out_ready && (r_out_idx == 4'd15)) w_state_nxt = S_FILL;
            end
            default: w_state_nxt = S_FILL;
        endcase
    end

    always_comb begin
        w_in_buf_nxt = r_in_buf;
        if (w_in_acc) w_in_buf_nxt[w_in_lsb +: 8] = bus.in_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_in_buf      <= '0;
            r_out_buf     <= '0;
            r_state_init  <= '0;
            r_in_idx      <= '0;
            r_out_idx     <= '0;
            r_wait_cnt    <= '0;
            r_enc_dec     <= 1'b0;
            r_err_timeout <= 1'b0;
            r_blk_count   <= '0;
            for (int k = 0; k < 16; k++) r_key[k] <= '0;
        end else begin
            if (w_in_acc) begin
                r_in_buf <= w_in_buf_nxt;
                r_in_idx <= r_in_idx + 4'd1;
            end
            // The core-facing block is a separate copy so FILL can reuse the ingress buffer.
            if (w_in_last) begin
                r_state_init <= w_in_buf_nxt;
                r_enc_dec    <= bus.mode_enc;
            end
            if (w_start)                 r_wait_cnt <= '0;
            else if (r_state == S_WAIT)  r_wait_cnt <= r_wait_cnt + 1'b1;
            if (w_timeout) r_err_timeout <= 1'b1;
            if (w_capture) begin
                r_out_buf   <= bus.aes_state_out;
                r_blk_count <= r_blk_count + 1'b1;
            end
            if (w_out_acc) r_out_idx <= r_out_idx + 4'd1;
            if (bus.key_wr_en && (r_state == S_FILL)) r_key[bus.key_wr_addr] <= bus.key_wr_data;
        end
    end

    assign bus.in_ready          = w_in_ready;
    assign bus.out_valid         = w_out_valid;
    assign bus.out_data          = r_out_buf[w_out_lsb +: 8];
    assign bus.aes_start         = w_start;
    assign bus.aes_state_init_en = w_init_en;
    assign bus.aes_state_init    = r_state_init;
    assign bus.aes_enc_dec       = r_enc_dec;
    assign bus.busy              = (r_state != S_FILL);
    assign bus.err_timeout       = r_err_timeout;
    assign bus.blk_count         = r_blk_count;

    // Column-major key layout: byte k feeds key_{k%4}{k/4}.
    assign bus.key_00 = r_key[0];
    assign bus.key_10 = r_key[1];
    assign bus.key_20 = r_key[2];
    assign bus.key_30 = r_key[3];
    assign bus.key_01 = r_key[4];
    assign bus.key_11 = r_key[5];
    assign bus.key_21 = r_key[6];
    assign bus.key_31 = r_key[7];
    assign bus.key_02 = r_key[8];
    assign bus.key_12 = r_key[9];
    assign bus.key_22 = r_key[10];
    assign bus.key_32 = r_key[11];
    assign bus.key_03 = r_key[12];
    assign bus.key_13 = r_key[13];
    assign bus.key_23 = r_key[14];
    assign bus.key_33 = r_key[15];
endmodule

// File: tb/tb_aes_pnm_stream_ctrl.sv
// Scoreboard bench for aes_pnm_stream_ctrl: the driver plays host and AES core and queues
// expected blocks and egress bytes; a negedge monitor pops and compares them.
module tb_aes_pnm_stream_ctrl;
    localparam int TMO = 24;
    localparam int CW  = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    aes_pnm_stream_ctrl_if #(.CNT_W(CW)) bus ();

    aes_pnm_stream_ctrl #(.TIMEOUT_CYCLES(TMO), .CNT_W(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0]   key_m [16];
    int           blk_m = 0;
    logic         err_m = 1'b0;
    logic [7:0]   exp_q[$];
    logic [128:0] exp_init_q[$];

    int   rdy_mode = 0;
    bit   tog = 1'b0;
    int   cyc = 0;
    int   acc_n = 0;
    int   cyc_acc = -100;
    logic prev_stall = 1'b0;
    logic [7:0] prev_data = '0;

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(posedge clk) begin
        #1;
        tog = ~tog;
        case (rdy_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = tog;
            default: bus.out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: everything here is sampled mid-cycle, after the driver has settled inputs.
    always @(negedge clk) begin
        logic [128:0] e;
        cyc++;
        if (rst) begin
            acc_n      = 0;
            prev_stall = 1'b0;
        end else begin
            if (bus.in_valid && bus.in_ready) begin
                acc_n++;
                if (acc_n == 16) begin
                    acc_n   = 0;
                    cyc_acc = cyc;
                end
            end
            if (bus.aes_state_init_en) begin
                chk("init_en_latency", 128'(cyc), 128'(cyc_acc + 1));
                chk("init_expected", 128'(exp_init_q.size() != 0), 128'(1));
                if (exp_init_q.size() != 0) begin
                    e = exp_init_q.pop_front();
                    chk("state_init", bus.aes_state_init, e[127:0]);
                    chk("enc_dec", 128'(bus.aes_enc_dec), 128'(e[128]));
                end
            end
            if (bus.aes_start) chk("start_latency", 128'(cyc), 128'(cyc_acc + 2));
            if (bus.out_valid) begin
                chk("drain_in_ready_busy", 128'({bus.in_ready, bus.busy}), 128'(2'b01));
                if (prev_stall) chk("out_data_stable", 128'(bus.out_data), 128'(prev_data));
                if (bus.out_ready) begin
                    chk("egress_expected", 128'(exp_q.size() != 0), 128'(1));
                    if (exp_q.size() != 0) chk("egress_byte", 128'(bus.out_data), 128'(exp_q.pop_front()));
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_data  = bus.out_data;
        end
    end

    task automatic check_keys(input string tag);
        logic [7:0] got [16];
        got[0]  = bus.key_00; got[1]  = bus.key_10; got[2]  = bus.key_20; got[3]  = bus.key_30;
        got[4]  = bus.key_01; got[5]  = bus.key_11; got[6]  = bus.key_21; got[7]  = bus.key_31;
        got[8]  = bus.key_02; got[9]  = bus.key_12; got[10] = bus.key_22; got[11] = bus.key_32;
        got[12] = bus.key_03; got[13] = bus.key_13; got[14] = bus.key_23; got[15] = bus.key_33;
        for (int k = 0; k < 16; k++) chk($sformatf("%s_key%0d", tag, k), 128'(got[k]), 128'(key_m[k]));
    endtask

    task automatic drive_key(input bit en);
        logic [3:0] a;
        logic [7:0] d;
        a = 4'($urandom);
        d = 8'($urandom);
        bus.key_wr_en   = en && ($urandom_range(0, 2) == 0);
        bus.key_wr_addr = a;
        bus.key_wr_data = d;
        if (bus.key_wr_en) key_m[a] = d;
    endtask

    task automatic feed_block(input logic [127:0] blk, input bit enc, input bit keys_rand);
        for (int i = 0; i < 16; i++) begin
            while ($urandom_range(0, 3) == 0) begin
                bus.in_valid = 1'b0;
                bus.in_data  = 8'($urandom);
                bus.mode_enc = 1'($urandom);
                drive_key(keys_rand);
                tick();
            end
            bus.in_valid = 1'b1;
            bus.in_data  = blk[127-8*i -: 8];
            bus.mode_enc = (i == 15) ? enc : 1'($urandom);
            drive_key(keys_rand);
            tick();
        end
        bus.in_valid  = 1'b0;
        bus.key_wr_en = 1'b0;
        bus.mode_enc  = 1'($urandom);
        exp_init_q.push_back({enc, blk});
    endtask

    task automatic model_reset();
        for (int k = 0; k < 16; k++) key_m[k] = 8'h00;
        blk_m = 0;
        err_m = 1'b0;
        exp_q.delete();
        exp_init_q.delete();
    endtask

    task automatic run_block(input logic [127:0] blk, input bit enc, input logic [127:0] mask,
                             input int lat, input int rmode, input bit wr_busy,
                             input int rst_after, input bit keys_rand);
        bit found;
        int n;
        int target;
        logic [127:0] res;
        rdy_mode = rmode;
        feed_block(blk, enc, keys_rand);
        found = 1'b0;
        for (int i = 0; i < 8 && !found; i++) begin
            @(negedge clk);
            if (bus.aes_start) found = 1'b1;
        end
        chk("start_seen", 128'(found), 128'(1));
        if (!found) return;
        for (int k = 1; k <= lat && k <= TMO; k++) begin
            tick();
            bus.key_wr_en   = wr_busy && (k == 1);
            bus.key_wr_addr = 4'd0;
            bus.key_wr_data = 8'hAA;
        end
        if (lat > TMO) begin
            chk("busy_last_wait", 128'(bus.busy), 128'(1));
            chk("err_before_timeout", 128'(bus.err_timeout), 128'(err_m));
            tick();
            err_m = 1'b1;
            chk("busy_after_timeout", 128'(bus.busy), 128'(0));
            chk("err_timeout_set", 128'(bus.err_timeout), 128'(err_m));
            chk("blk_count_timeout", 128'(bus.blk_count), 128'(blk_m));
            repeat (3) tick();
            return;
        end
        res               = blk ^ mask;
        bus.aes_done      = 1'b1;
        bus.aes_state_out = res;
        for (int b = 0; b < 16; b++) exp_q.push_back(res[127-8*b -: 8]);
        blk_m = (blk_m + 1) % (1 << CW);
        tick();
        bus.key_wr_en = 1'b0;
        repeat (2) tick();
        bus.aes_done      = 1'b0;
        bus.aes_state_out = {$urandom, $urandom, $urandom, $urandom};
        target = (rst_after > 0) ? 16 - rst_after : 0;
        n = 0;
        while (exp_q.size() > target && n < 400) begin
            tick();
            n++;
        end
        chk("drain_progress", 128'(exp_q.size()), 128'(target));
        if (rst_after > 0) begin
            rst = 1'b1;
            model_reset();
            tick();
            rst = 1'b0;
            chk("rst_out_valid", 128'(bus.out_valid), 128'(0));
            chk("rst_in_ready", 128'(bus.in_ready), 128'(1));
            chk("rst_blk_count", 128'(bus.blk_count), 128'(blk_m));
            chk("rst_err", 128'(bus.err_timeout), 128'(err_m));
            chk("rst_state_init", bus.aes_state_init, 128'(0));
            check_keys("rst");
        end else begin
            chk("idle_after_drain", 128'({bus.busy, bus.out_valid, bus.in_ready}), 128'(3'b001));
            chk("blk_count", 128'(bus.blk_count), 128'(blk_m));
            chk("err_sticky", 128'(bus.err_timeout), 128'(err_m));
        end
    endtask

    initial begin
        bus.key_wr_en     = 1'b0;
        bus.key_wr_addr   = '0;
        bus.key_wr_data   = '0;
        bus.mode_enc      = 1'b0;
        bus.in_valid      = 1'b0;
        bus.in_data       = '0;
        bus.aes_done      = 1'b0;
        bus.aes_state_out = '0;
        model_reset();
        repeat (3) tick();
        rst = 1'b0;
        chk("reset_outputs", 128'({bus.out_valid, bus.busy, bus.err_timeout, bus.aes_start,
                                   bus.aes_state_init_en, bus.aes_enc_dec, bus.in_ready}), 128'(7'b0000001));
        chk("reset_blk_count", 128'(bus.blk_count), 128'(0));
        chk("reset_state_init", bus.aes_state_init, 128'(0));
        check_keys("reset");

        for (int k = 0; k < 16; k++) begin
            bus.key_wr_en   = 1'b1;
            bus.key_wr_addr = 4'(k);
            bus.key_wr_data = 8'(k);
            key_m[k]        = 8'(k);
            tick();
        end
        bus.key_wr_en = 1'b0;
        chk("key_00", 128'(bus.key_00), 128'(8'h00));
        chk("key_10", 128'(bus.key_10), 128'(8'h01));
        chk("key_01", 128'(bus.key_01), 128'(8'h04));
        chk("key_33", 128'(bus.key_33), 128'(8'h0F));
        chk("key_load_busy", 128'(bus.busy), 128'(0));
        check_keys("load");

        run_block(128'h00112233445566778899aabbccddeeff, 1'b1, {128{1'b1}}, 20, 0, 1'b0, 0, 1'b0);
        run_block({$urandom, $urandom, $urandom, $urandom}, 1'b0, {$urandom, $urandom, $urandom, $urandom},
                  $urandom_range(1, TMO), 1, 1'b0, 0, 1'b0);
        run_block({$urandom, $urandom, $urandom, $urandom}, 1'b1, '0, TMO + 5, 0, 1'b0, 0, 1'b0);
        run_block({$urandom, $urandom, $urandom, $urandom}, 1'b0, {$urandom, $urandom, $urandom, $urandom},
                  TMO, 1, 1'b0, 0, 1'b0);

        run_block({$urandom, $urandom, $urandom, $urandom}, 1'b1, {$urandom, $urandom, $urandom, $urandom},
                  10, 0, 1'b1, 0, 1'b0);
        check_keys("busy_write");
        bus.key_wr_en   = 1'b1;
        bus.key_wr_addr = 4'd0;
        bus.key_wr_data = 8'hAA;
        key_m[0]        = 8'hAA;
        tick();
        bus.key_wr_en = 1'b0;
        chk("key_00_after_drain", 128'(bus.key_00), 128'(8'hAA));

        for (int b = 0; b < 8; b++) begin
            run_block({$urandom, $urandom, $urandom, $urandom}, 1'($urandom),
                      {$urandom, $urandom, $urandom, $urandom}, $urandom_range(1, TMO + 2),
                      $urandom_range(0, 2), 1'b0, 0, 1'b1);
            check_keys($sformatf("rand%0d", b));
        end

        run_block({$urandom, $urandom, $urandom, $urandom}, 1'b1, {$urandom, $urandom, $urandom, $urandom},
                  6, 0, 1'b0, 5, 1'b0);
        run_block({$urandom, $urandom, $urandom, $urandom}, 1'b0, {$urandom, $urandom, $urandom, $urandom},
                  12, 2, 1'b0, 0, 1'b0);

        repeat (4) tick();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", n_checks, n_errors);
        $fatal(1);
    end
endmodule
